// File: rtl/bullet_engine.sv
// bullet_engine: single enemy bullet for the dodge phase
// Spawns from a random edge, flies in a straight line, exits or hits the heart.
module bullet_engine #(
    parameter int          AREA_MAX       = 200,
    parameter int          SPEED          = 2,
    parameter int          RESPAWN_FRAMES = 30,
    parameter int          HEART_R        = 8,
    parameter int          SMALL_R        = 8,
    parameter int          BLUE_R         = 50,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic [15:0] playerPos,
    output logic [15:0] bulletPos,
    output logic [1:0]  bulletColor,
    output logic        isRender,
    output logic        hit,
    output logic [1:0]  hitColor
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SPAWN, S_FLY, S_CHECK} state_t;
    localparam int CW = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(RESPAWN_FRAMES);

    state_t        state;
    logic [15:0]   lfsr;
    logic [CW-1:0] counter;
    logic          hit_done;
    logic [1:0]    dir;
    logic [7:0]    bx, by, px, py, coord, step, lane, edge_pos;
    logic [8:0]    dx, dy, reach;
    logic          fwd, leaves, collide;

    assign {bx, by} = bulletPos;
    assign {px, py} = playerPos;
    // dir[1] selects the y axis, dir[0] selects the negative direction
    assign fwd      = ~dir[0];
    assign coord    = dir[1] ? by : bx;
    assign leaves   = fwd ? (({1'b0, coord} + 9'(SPEED)) > 9'(AREA_MAX)) : (coord < 8'(SPEED));
    assign step     = fwd ? coord + 8'(SPEED) : coord - 8'(SPEED);
    assign lane     = {1'b0, lfsr[9:3]} + 8'd36;
    assign edge_pos = lfsr[0] ? 8'(AREA_MAX) : 8'd0;
    assign dx       = bx >= px ? {1'b0, bx - px} : {1'b0, px - bx};
    assign dy       = by >= py ? {1'b0, by - py} : {1'b0, py - by};
    assign reach    = bulletColor == 2'd2 ? 9'(HEART_R + BLUE_R) : 9'(HEART_R + SMALL_R);
    assign collide  = dx <= reach && dy <= reach && !hit_done && isRender;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            lfsr        <= LFSR_SEED;
            counter     <= '0;
            hit_done    <= 1'b0;
            dir         <= 2'd0;
            bulletPos   <= 16'd0;
            bulletColor <= 2'd0;
            isRender    <= 1'b0;
            hit         <= 1'b0;
            hitColor    <= 2'd0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            hit  <= 1'b0;
            if (!enable) begin
                state    <= S_IDLE;
                isRender <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_WAIT;
                        counter <= RELOAD;
                    end
                    S_WAIT: if (frame_tick) begin
                        if (counter == '0) state <= S_SPAWN;
                        else counter <= counter - 1'b1;
                    end
                    S_SPAWN: begin
                        bulletPos   <= lfsr[1] ? {lane, edge_pos} : {edge_pos, lane};
                        dir         <= lfsr[1:0];
                        bulletColor <= lfsr[12:10] == 3'd7 ? 2'd2 : lfsr[12:10] >= 3'd5 ? 2'd1 : 2'd0;
                        hit_done    <= 1'b0;
                        isRender    <= 1'b1;
                        state       <= S_FLY;
                    end
                    S_FLY: if (frame_tick) begin
                        if (leaves) begin
                            isRender <= 1'b0;
                            counter  <= RELOAD;
                            state    <= S_WAIT;
                        end else begin
                            if (dir[1]) bulletPos[7:0] <= step;
                            else bulletPos[15:8] <= step;
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        state <= S_FLY;
                        if (collide) begin
                            hit      <= 1'b1;
                            hitColor <= bulletColor;
                            // blue passes through the heart; small bullets are consumed
                            if (bulletColor == 2'd2) hit_done <= 1'b1;
                            else begin
                                isRender <= 1'b0;
                                counter  <= RELOAD;
                                state    <= S_WAIT;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: directed checks of spawn, flight, exit, hits and enable drop
module tb_bullet_engine;
    localparam int RESP = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] player_pos = 16'h6464;
    logic [15:0] bullet_pos;
    logic [1:0]  bullet_color;
    logic        is_render;
    logic        hit;
    logic [1:0]  hit_color;

    int          tests = 0;
    int          errors = 0;
    int          hit_cnt = 0;
    logic [1:0]  last_hit_color = 2'd3;
    logic [15:0] lfsr_m;
    logic [15:0] sl;
    logic [7:0]  lane;
    int          h0;

    bullet_engine dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .playerPos(player_pos), .bulletPos(bullet_pos), .bulletColor(bullet_color),
        .isRender(is_render), .hit(hit), .hitColor(hit_color)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] spawn_pos(input logic [15:0] l);
        logic [7:0] ln, e;
        ln = {1'b0, l[9:3]} + 8'd36;
        e  = l[0] ? 8'd200 : 8'd0;
        return l[1] ? {ln, e} : {e, ln};
    endfunction

    function automatic logic [1:0] col_of(input logic [15:0] l);
        return l[12:10] == 3'd7 ? 2'd2 : l[12:10] >= 3'd5 ? 2'd1 : 2'd0;
    endfunction

    always @(posedge clk or posedge reset) lfsr_m <= reset ? 16'hACE1 : lfsr_next(lfsr_m);

    // every cycle hit is high adds one, so a stretched pulse shows up as an extra count
    always @(posedge clk) begin
        #2;
        if (hit) begin
            hit_cnt++;
            last_hit_color = hit_color;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // 30 idle ticks, then the 31st tick timed so the sampled LFSR gives the wanted edge/colour
    task automatic spawn(input int want_edge, input int want_col, output logic [15:0] l);
        logic        saw;
        logic [15:0] nl;
        logic [7:0]  ln;
        int          n;
        saw = 1'b0;
        for (int i = 0; i < RESP; i++) begin
            tick();
            saw |= is_render;
        end
        check("wait_norender", saw, 0);
        n  = 0;
        nl = lfsr_next(lfsr_m);
        while (want_edge >= 0 && n < 4000 &&
               !(nl[1:0] == want_edge[1:0] && col_of(nl) == want_col[1:0])) begin
            @(negedge clk);
            nl = lfsr_next(lfsr_m);
            n++;
        end
        if (want_edge >= 0) check("seed_search", n < 4000, 1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        l = lfsr_m;
        check("spawn_not_yet", is_render, 0);
        @(negedge clk);
        check("spawn_render", is_render, 1);
        check("spawn_pos", bullet_pos, spawn_pos(l));
        check("spawn_color", bullet_color, col_of(l));
        ln = l[1] ? bullet_pos[15:8] : bullet_pos[7:0];
        check("lane_range", ln >= 8'd36 && ln <= 8'd163, 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pos", bullet_pos, 0);
        check("rst_color", bullet_color, 0);
        check("rst_render", is_render, 0);
        check("rst_hit", hit, 0);
        check("rst_hitcolor", hit_color, 0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // generic respawn, then asynchronous reset mid-flight
        spawn(-1, 0, sl);
        #2 reset = 1'b1;
        #1;
        check("async_pos", bullet_pos, 0);
        check("async_color", bullet_color, 0);
        check("async_render", is_render, 0);
        check("async_hit", hit, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // left-edge white bullet crosses the whole area and exits
        spawn(0, 0, sl);
        lane = bullet_pos[7:0];
        player_pos = {8'd100, lane < 8'd100 ? 8'd200 : 8'd0};
        h0 = hit_cnt;
        for (int i = 0; i < 100; i++) tick();
        check("exit_pos200", bullet_pos, {8'd200, lane});
        check("exit_alive", is_render, 1);
        tick();
        check("exit_render", is_render, 0);
        check("exit_pos_hold", bullet_pos, {8'd200, lane});
        check("exit_nohit", hit_cnt, h0);

        // white hit at dx=16, none at dx=18
        spawn(0, 0, sl);
        lane = bullet_pos[7:0];
        player_pos = {8'd40, lane};
        h0 = hit_cnt;
        for (int i = 0; i < 11; i++) tick();
        check("white_dx18_nohit", hit_cnt, h0);
        check("white_dx18_render", is_render, 1);
        tick();
        check("white_hit_once", hit_cnt, h0 + 1);
        check("white_hitcolor", last_hit_color, 0);
        check("white_render", is_render, 0);
        check("white_hit_low", hit, 0);
        check("white_pos", bullet_pos, {8'd24, lane});

        // blue passes through the heart: single hit, keeps flying
        spawn(0, 2, sl);
        lane = bullet_pos[7:0];
        player_pos = {8'd100, lane};
        h0 = hit_cnt;
        for (int i = 0; i < 100; i++) tick();
        check("blue_one_hit", hit_cnt, h0 + 1);
        check("blue_hitcolor", last_hit_color, 2);
        check("blue_alive", is_render, 1);
        check("blue_pos200", bullet_pos, {8'd200, lane});
        tick();
        check("blue_exit", is_render, 0);
        check("blue_still_one", hit_cnt, h0 + 1);

        // enable drops on the colliding CHECK cycle
        spawn(0, 0, sl);
        lane = bullet_pos[7:0];
        player_pos = {8'd40, lane};
        h0 = hit_cnt;
        for (int i = 0; i < 11; i++) tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drop_nohit", hit_cnt, h0);
        check("drop_render", is_render, 0);
        check("drop_pos_hold", bullet_pos, {8'd24, lane});
        enable = 1'b1;
        @(negedge clk);
        spawn(-1, 0, sl);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/bullet_engine.md
Name: bullet_engine

Overview:
Generates the single enemy bullet for the dodge phase: spawn, motion, exit and collision against the player heart. Drives the renderer's bulletPos/bulletColor/isRender inputs and emits a one-cycle hit pulse that the game-state/HP logic consumes. All positions use play-area coordinates {x[7:0],y[7:0]}, 0..AREA_MAX, the same format as playerPos.

Parameters:
AREA_MAX, 200, max play-area coordinate on each axis
SPEED, 2, coordinate step per frame_tick
RESPAWN_FRAMES, 30, frame_ticks idle between bullet lifetimes
HEART_R, 8, heart half-size
SMALL_R, 8, half-size of white/green bullet
BLUE_R, 50, half-size of blue bullet
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame (min 3 cycles apart)
enable  in  1  dodge phase active
playerPos  in  16  {x,y} heart centre
bulletPos  out  16  {x,y} bullet centre
bulletColor  out  2  0 white (damage), 1 green (heal), 2 blue (large, damage)
isRender  out  1  bullet alive/visible
hit  out  1  one-cycle collision pulse
hitColor  out  2  colour of bullet that caused hit, valid with hit

Behaviour:
- Reset (async): state IDLE, bulletPos=0, bulletColor=0, isRender=0, hit=0, hitColor=0, lfsr=LFSR_SEED, counter=0, hit_done=0.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every clk cycle out of reset, regardless of state.
- States: IDLE, WAIT, SPAWN, FLY, CHECK.
- IDLE: isRender=0. enable=1 -> WAIT, counter=RESPAWN_FRAMES.
- WAIT: on frame_tick, counter==0 -> SPAWN, else counter-1. With default 30, spawn follows the 31st frame_tick.
- SPAWN (1 cycle): sample lfsr. lane={1'b0,lfsr[9:3]}+36 (36..163). Edge lfsr[1:0]: 0 left (x=0,y=lane,+x), 1 right (x=AREA_MAX,-x), 2 top (y=0,x=lane,+y), 3 bottom (y=AREA_MAX,-y). Colour from lfsr[12:10]: 0..4 white, 5..6 green, 7 blue. Set hit_done=0, isRender=1, then go to FLY.
- FLY: on frame_tick, if the step would leave 0..AREA_MAX (e.g. +x with x+SPEED>AREA_MAX, -x with x<SPEED), set isRender=0 and go to WAIT with counter reloaded. Otherwise move by SPEED and go to CHECK.
- CHECK (1 cycle): dx=|bx-px|, dy=|by-py|, 9-bit unsigned. R=BLUE_R if colour 2, else SMALL_R. Collision when dx<=HEART_R+R and dy<=HEART_R+R and hit_done=0.
  - Collision with white/green: hit=1 for the next cycle, hitColor=colour, isRender=0, go to WAIT (counter reloaded).
  - Collision with blue: hit=1 next cycle, hit_done=1, return to FLY. A blue bullet hits at most once per lifetime.
  - No collision: return to FLY.
- Timing: frame_tick sampled at edge k gives new bulletPos after edge k. hit is high after edge k+1 for exactly one cycle.
- frame_tick arriving during SPAWN or CHECK is dropped.
- enable=0 in any state: next edge goes to IDLE with isRender=0 and hit=0; any pending hit is discarded. bulletPos and bulletColor hold their values.
- A frame_tick that coincides with enable falling is ignored.
- hit never stays high for more than 1 cycle; hit only rises when isRender was 1 in the preceding CHECK.

Test Plan:
- Reset: assert reset mid-FLY -> all outputs 0 asynchronously. After release, the LFSR first value is LFSR_SEED.
- Respawn: enable=1, 30 frame_ticks -> isRender stays 0. 31st tick -> SPAWN; isRender=1 two edges later; bulletPos on the spawn edge with lane in 36..163.
- Exit: force left spawn at x=0 (bench-chosen seed) -> x=200 after 100 ticks. 101st tick -> isRender=0 and no hit.
- White hit: after a +x white spawn, set playerPos={x+40,y} -> hit on the 12th tick (dx=16), pulse width 1, hitColor=0, isRender=0 after. No hit at dx=18.
- Blue: blue bullet passes through heart -> exactly one hit pulse, hitColor=2, bullet keeps flying until exit.
- enable drop: deassert enable in the same cycle as CHECK collision -> no hit pulse, IDLE, isRender=0. Re-enable -> waits the full RESPAWN_FRAMES again.
